// File: rtl/switch_debouncer_if.sv
// Switch bundle between the raw board switches and the debouncer.
// The slave side is the debouncer; the master side is whatever drives the raw levels.
interface switch_debouncer_if #(
   parameter int NUM_SW = 2
);
   logic [NUM_SW-1:0] i_switch;
   logic [NUM_SW-1:0] o_switch;
   logic [NUM_SW-1:0] o_rise;
   logic [NUM_SW-1:0] o_fall;

   modport master (
      output i_switch,
      input  o_switch,
      input  o_rise,
      input  o_fall
   );

   modport slave (
      input  i_switch,
      output o_switch,
      output o_rise,
      output o_fall
   );
endinterface

// File: rtl/switch_debouncer.sv
// Per-channel synchroniser plus stability-counter debouncer for the board slide switches.
// Define SWITCH_DEBOUNCE_EDGE_EN to build the one-cycle o_rise/o_fall pulse registers.
module switch_debouncer #(
   parameter int NUM_SW           = 2,
   parameter int SYNC_STAGES      = 2,
   parameter int c_DEBOUNCE_COUNT = 500000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   switch_debouncer_if.slave  sw
);

   localparam int CNT_W = (c_DEBOUNCE_COUNT > 1) ? $clog2(c_DEBOUNCE_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_DEBOUNCE_COUNT - 1);

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q [NUM_SW];
   logic [NUM_SW-1:0]      s;

   state_t                 state_q [NUM_SW];
   state_t                 state_d [NUM_SW];
   logic [CNT_W-1:0]       cnt_q   [NUM_SW];
   logic [CNT_W-1:0]       cnt_d   [NUM_SW];
   logic [NUM_SW-1:0]      level_q;
   logic [NUM_SW-1:0]      level_d;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int k = 0; k < NUM_SW; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_SW; k++) begin
            sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], sw.i_switch[k]};
         end
      end
   end

   always_comb begin
      s = '0;
      for (int k = 0; k < NUM_SW; k++) begin
         s[k] = sync_q[k][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int k = 0; k < NUM_SW; k++) begin
            state_q[k] <= STABLE_LO;
            cnt_q[k]   <= '0;
         end
         level_q <= '0;
      end else begin
         for (int k = 0; k < NUM_SW; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         level_q <= level_d;
      end
   end

   // A WAIT state only commits once the opposite level has been seen on every
   // edge of the window; any agreeing sample throws the partial count away.
   always_comb begin
      level_d = level_q;
      for (int k = 0; k < NUM_SW; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            STABLE_LO: begin
               if (s[k]) begin
                  state_d[k] = WAIT_HI;
                  cnt_d[k]   = '0;
               end
            end
            WAIT_HI: begin
               if (!s[k]) begin
                  state_d[k] = STABLE_LO;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = STABLE_HI;
                  level_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            STABLE_HI: begin
               if (!s[k]) begin
                  state_d[k] = WAIT_LO;
                  cnt_d[k]   = '0;
               end
            end
            WAIT_LO: begin
               if (s[k]) begin
                  state_d[k] = STABLE_HI;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = STABLE_LO;
                  level_d[k] = 1'b0;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            default: begin
               state_d[k] = STABLE_LO;
               cnt_d[k]   = '0;
            end
         endcase
      end
   end

   assign sw.o_switch = level_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic [NUM_SW-1:0] rise_q;
   logic [NUM_SW-1:0] fall_q;

   // Outside reset the debounced level only moves on acceptance, so a level
   // difference is exactly one accepted transition.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= level_d & ~level_q;
         fall_q <= ~level_d & level_q;
      end
   end

   assign sw.o_rise = rise_q;
   assign sw.o_fall = fall_q;
`else
   assign sw.o_rise = '0;
   assign sw.o_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed literal checks plus randomized switch activity
// compared every cycle against a run-length model of the debounce rules.
module tb_switch_debouncer;

   localparam int NUM_SW           = 2;
   localparam int SYNC_STAGES      = 2;
   localparam int c_DEBOUNCE_COUNT = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EDGE_ON = 1'b1;
`else
   localparam bit EDGE_ON = 1'b0;
`endif

   logic clk;
   logic rstN;
   int   compared;
   int   mismatched;

   switch_debouncer_if #(.NUM_SW(NUM_SW)) bus ();

   switch_debouncer #(
      .NUM_SW           (NUM_SW),
      .SYNC_STAGES      (SYNC_STAGES),
      .c_DEBOUNCE_COUNT (c_DEBOUNCE_COUNT)
   ) dut (
      .i_clk   (clk),
      .i_reset (rstN),
      .sw      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-edge history of raw input and reset
   logic [NUM_SW-1:0] iHist [$];
   bit                rHist [$];
   int                runLen [NUM_SW];
   logic [NUM_SW-1:0] modelLevel = '0;
   logic [NUM_SW-1:0] expRise    = '0;
   logic [NUM_SW-1:0] expFall    = '0;

   // Synchronised level after edge m: raw input from SYNC_STAGES-1 edges
   // earlier, or 0 if reset hit any edge of that window.
   function automatic logic [NUM_SW-1:0] syncedAfter(int m);
      if (m - SYNC_STAGES + 1 < 0) return '0;
      for (int j = m - SYNC_STAGES + 1; j <= m; j++) begin
         if (rHist[j]) return '0;
      end
      return iHist[m - SYNC_STAGES + 1];
   endfunction

   // A level is accepted once the synchronised value has disagreed with the
   // debounced output on c_DEBOUNCE_COUNT+1 consecutive edges.
   always @(posedge clk) begin : model
      logic [NUM_SW-1:0] sVis;
      int n;
      iHist.push_back(bus.i_switch);
      rHist.push_back(!rstN);
      n = iHist.size() - 1;
      expRise = '0;
      expFall = '0;
      if (!rstN) begin
         modelLevel = '0;
         for (int k = 0; k < NUM_SW; k++) runLen[k] = 0;
      end else begin
         sVis = syncedAfter(n - 1);
         for (int k = 0; k < NUM_SW; k++) begin
            if (sVis[k] !== modelLevel[k]) begin
               runLen[k]++;
               if (runLen[k] == c_DEBOUNCE_COUNT + 1) begin
                  modelLevel[k] = sVis[k];
                  runLen[k]     = 0;
                  if (sVis[k]) expRise[k] = 1'b1;
                  else         expFall[k] = 1'b1;
               end
            end else begin
               runLen[k] = 0;
            end
         end
      end
      if (!EDGE_ON) begin
         expRise = '0;
         expFall = '0;
      end
   end

   task automatic checkOutput(input string name, input logic [NUM_SW-1:0] act,
                              input logic [NUM_SW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("model o_switch", bus.o_switch, modelLevel);
      checkOutput("model o_rise",   bus.o_rise,   expRise);
      checkOutput("model o_fall",   bus.o_fall,   expFall);
   end

   // Drive at the current falling edge, then advance the given number of rising edges
   task automatic applyStimulus(input logic [NUM_SW-1:0] swVal, input logic rstVal,
                                input int cycles);
      bus.i_switch = swVal;
      rstN         = rstVal;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      int holdLen;
      logic [NUM_SW-1:0] val;
      compared   = 0;
      mismatched = 0;
      bus.i_switch = 2'b11;
      rstN         = 1'b0;
      @(negedge clk);

      // Reset held three edges with both switches high
      checkOutput("reset o_switch", bus.o_switch, 2'b00);
      applyStimulus(2'b11, 1'b0, 2);
      checkOutput("reset o_switch end", bus.o_switch, 2'b00);
      checkOutput("reset o_rise", bus.o_rise, 2'b00);
      applyStimulus(2'b11, 1'b1, 6);
      checkOutput("release edge6 o_switch", bus.o_switch, 2'b00);
      applyStimulus(2'b11, 1'b1, 1);
      checkOutput("release edge7 o_switch", bus.o_switch, 2'b11);
      checkOutput("release edge7 o_rise", bus.o_rise, EDGE_ON ? 2'b11 : 2'b00);
      applyStimulus(2'b11, 1'b1, 1);
      checkOutput("release edge8 o_rise", bus.o_rise, 2'b00);

      // Clean fall on both channels
      applyStimulus(2'b00, 1'b1, 6);
      checkOutput("fall edge6 o_switch", bus.o_switch, 2'b11);
      applyStimulus(2'b00, 1'b1, 1);
      checkOutput("fall edge7 o_switch", bus.o_switch, 2'b00);
      checkOutput("fall edge7 o_fall", bus.o_fall, EDGE_ON ? 2'b11 : 2'b00);

      // Short pulse of c_DEBOUNCE_COUNT clocks is rejected
      applyStimulus(2'b01, 1'b1, 4);
      applyStimulus(2'b00, 1'b1, 12);
      checkOutput("short pulse o_switch", bus.o_switch, 2'b00);

      // Bounce on channel 1, then held high
      applyStimulus(2'b10, 1'b1, 3);
      applyStimulus(2'b00, 1'b1, 1);
      applyStimulus(2'b10, 1'b1, 6);
      checkOutput("bounce edge6 o_switch", bus.o_switch, 2'b00);
      applyStimulus(2'b10, 1'b1, 1);
      checkOutput("bounce edge7 o_switch", bus.o_switch, 2'b10);
      checkOutput("bounce edge7 o_rise", bus.o_rise, EDGE_ON ? 2'b10 : 2'b00);

      // Reset in the middle of qualification on channel 0
      applyStimulus(2'b00, 1'b1, 10);
      checkOutput("settle low o_switch", bus.o_switch, 2'b00);
      applyStimulus(2'b01, 1'b1, 4);
      applyStimulus(2'b01, 1'b0, 1);
      applyStimulus(2'b01, 1'b1, 6);
      checkOutput("midwait edge6 o_switch", bus.o_switch, 2'b00);
      applyStimulus(2'b01, 1'b1, 1);
      checkOutput("midwait edge7 o_switch", bus.o_switch, 2'b01);
      checkOutput("midwait edge7 o_rise", bus.o_rise, EDGE_ON ? 2'b01 : 2'b00);

      // Randomized activity with occasional resets, checked by the model
      for (int i = 0; i < 400; i++) begin
         val     = NUM_SW'($urandom_range(0, 3));
         holdLen = $urandom_range(1, 8);
         if ($urandom_range(0, 39) == 0) applyStimulus(val, 1'b0, $urandom_range(1, 2));
         applyStimulus(val, 1'b1, holdLen);
      end
      applyStimulus(2'b00, 1'b1, 12);
      checkOutput("final o_switch", bus.o_switch, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
